// File: rtl/wb_port_arb_if.sv
// Bus bundle between the write-back stage producers and the register-file write-port arbiter.
// The arbiter sits on the slave side. The producers and the register file sit on the master side.
interface wb_port_arb_if #(
  parameter int unsigned REGBITS = 5,
  parameter int unsigned LOGSIZE = 64
);
  logic               alu_valid;
  logic [REGBITS-1:0] alu_rd;
  logic [LOGSIZE-1:0] alu_data;
  logic               alu_ready;
  logic               ld_valid;
  logic [REGBITS-1:0] ld_rd;
  logic [LOGSIZE-1:0] ld_data;
  logic               ld_ready;
  logic               wb_flush;
  logic               ecall_req;
  logic [31:0]        ecall_pc;
  logic               ecall_start;
  logic               ecall_done;
  logic [LOGSIZE-1:0] ecall_result;
  logic               rf_we;
  logic [REGBITS-1:0] rf_waddr;
  logic [LOGSIZE-1:0] rf_wdata;
  logic               ecall_flush;
  logic [31:0]        pc_after_flush;
  logic               busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, wb_flush,
           ecall_req, ecall_pc, ecall_done, ecall_result,
    output alu_ready, ld_ready, ecall_start, rf_we, rf_waddr, rf_wdata,
           ecall_flush, pc_after_flush, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, wb_flush,
           ecall_req, ecall_pc, ecall_done, ecall_result,
    input  alu_ready, ld_ready, ecall_start, rf_we, rf_waddr, rf_wdata,
           ecall_flush, pc_after_flush, busy
  );
endinterface

// File: rtl/wb_port_arb.sv
// Single register-file write port. It arbitrates between ALU results, queued late loads and ECALL.
// It also sequences ECALL: drain the queued loads, launch the call, write a0, then flush.
module wb_port_arb #(
  parameter int unsigned REGBITS    = 5,
  parameter int unsigned LOGSIZE    = 64,
  parameter int unsigned LQ_DEPTH   = 2,
  parameter int unsigned STARVE_LIM = 3
) (
  input logic           clk,
  input logic           rst,
  wb_port_arb_if.slave  bus
);
  localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CW-1:0]      LQ_FULL_CNT = CW'(LQ_DEPTH);
  localparam logic [SW-1:0]      S_LIM       = SW'(STARVE_LIM);
  localparam logic [REGBITS-1:0] REG_A0      = REGBITS'(10);

  typedef enum logic [1:0] {IDLE, DRAIN, CALL, WRITE} state_e;
  state_e state_q, state_d;

  logic [REGBITS-1:0] lq_rd_q   [LQ_DEPTH];
  logic [LOGSIZE-1:0] lq_data_q [LQ_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic [SW-1:0]      starve_q, starve_d;
  logic               lq_full, lq_empty, push, pop;
  logic               grant_alu, grant_fifo;

  logic               rf_we_q, rf_we_d;
  logic [REGBITS-1:0] rf_waddr_q, rf_waddr_d;
  logic [LOGSIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic               flush_q, flush_d;
  logic [31:0]        pc_q, pc_d;
  logic               start_q, start_d;

  assign lq_full  = (cnt_q == LQ_FULL_CNT);
  assign lq_empty = (cnt_q == '0);
  assign push     = bus.ld_valid && !lq_full;
  assign pop      = grant_fifo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.ecall_req) state_d = DRAIN;
      DRAIN:   if (lq_empty && !push) state_d = CALL;
      CALL:    if (bus.ecall_done) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_alu  = 1'b0;
    grant_fifo = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    flush_d    = 1'b0;
    pc_d       = pc_q;
    start_d    = (state_q == DRAIN) && (state_d == CALL);
    unique case (state_q)
      IDLE: begin
        if (!lq_empty && (lq_full || starve_q == S_LIM)) grant_fifo = 1'b1;
        else if (bus.alu_valid)                          grant_alu  = 1'b1;
        else if (!lq_empty)                              grant_fifo = 1'b1;
      end
      DRAIN, WRITE: grant_fifo = !lq_empty;
      CALL: begin
        if (bus.ecall_done) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = REG_A0;
          rf_wdata_d = bus.ecall_result;
          flush_d    = 1'b1;
          pc_d       = bus.ecall_pc + 32'd4;
        end
      end
      default: ;
    endcase
    // A flushed ALU result is still consumed; it just never reaches the register file.
    if (grant_fifo) begin
      rf_we_d    = (lq_rd_q[rd_ptr_q] != '0);
      rf_waddr_d = lq_rd_q[rd_ptr_q];
      rf_wdata_d = lq_data_q[rd_ptr_q];
    end else if (grant_alu) begin
      rf_we_d    = !bus.wb_flush && (bus.alu_rd != '0);
      rf_waddr_d = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end
    if (lq_empty || grant_fifo) starve_d = '0;
    else if (starve_q != S_LIM) starve_d = starve_q + 1'b1;
    else                        starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_q[i]   <= '0;
        lq_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      flush_q    <= 1'b0;
      pc_q       <= '0;
      start_q    <= 1'b0;
    end else begin
      if (push) begin
        lq_rd_q[wr_ptr_q]   <= bus.ld_rd;
        lq_data_q[wr_ptr_q] <= bus.ld_data;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      flush_q    <= flush_d;
      pc_q       <= pc_d;
      start_q    <= start_d;
    end
  end

  assign bus.alu_ready      = grant_alu;
  assign bus.ld_ready       = !lq_full;
  assign bus.ecall_start    = start_q;
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_waddr       = rf_waddr_q;
  assign bus.rf_wdata       = rf_wdata_q;
  assign bus.ecall_flush    = flush_q;
  assign bus.pc_after_flush = pc_q;
  assign bus.busy           = (state_q != IDLE);
endmodule
